// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and encodings for the pipeline hazard controller
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} hz_state_t;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [2:0] RES_LOAD = 3'b001;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - E-stage operand forwarding select for one source register
module forward_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] rs_e,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   output logic [1:0] fwd_sel
);

   // M holds the younger result, so it wins over W
   always_comb begin
      fwd_sel = FWD_RF;
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
         fwd_sel = FWD_M;
      end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
         fwd_sel = FWD_W;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forward control with memory-wait timeout and perf counters
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32,
   parameter logic [2:0]  LOAD_SRC    = RES_LOAD
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic [2:0]       ResultSrcE,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             DMemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemFault,
   output logic [CNT_W-1:0] StallCycles,
   output logic [CNT_W-1:0] FlushEvents
);

   localparam logic [15:0] TIMEOUT_C = 16'(MEM_TIMEOUT);

   hz_state_t        state_q, state_d;
   logic [15:0]      wait_cnt_q, wait_cnt_d;
   logic             mem_fault_q, mem_fault_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_events_q, flush_events_d;

   logic lw_stall;
   logic mem_stall;
   logic hold_all;

   forward_unit u_fwd_a (
      .rs_e        (Rs1E),
      .rd_m        (RdM),
      .rd_w        (RdW),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .fwd_sel     (ForwardAE)
   );

   forward_unit u_fwd_b (
      .rs_e        (Rs2E),
      .rd_m        (RdM),
      .rd_w        (RdW),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .fwd_sel     (ForwardBE)
   );

   // A memory wait or fault freezes every stage, so no held stage is ever flushed
   always_comb begin
      lw_stall  = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
      mem_stall = MemReqM && !DMemReadyM;
      hold_all  = (state_q == FAULT) || mem_stall;
      StallF    = hold_all || lw_stall;
      StallD    = hold_all || lw_stall;
      StallE    = hold_all;
      StallM    = hold_all;
      FlushW    = hold_all;
      FlushD    = !hold_all && PCSrcE;
      FlushE    = !hold_all && (lw_stall || PCSrcE);
      MemFault  = mem_fault_q;
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_fault_d = mem_fault_q;
      case (state_q)
         RUN: begin
            if (mem_stall) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = 16'd1;
            end
         end
         MEM_WAIT: begin
            if (DMemReadyM) begin
               state_d    = RUN;
               wait_cnt_d = 16'd0;
            end else if (wait_cnt_q == TIMEOUT_C) begin
               state_d     = FAULT;
               mem_fault_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         FAULT: begin
            mem_fault_d = 1'b1;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = 16'd0;
         end
      endcase
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if ((StallF || StallD || StallE || StallM) && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      if (FlushD && (flush_events_q != '1)) begin
         flush_events_d = flush_events_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= RUN;
         wait_cnt_q     <= 16'd0;
         mem_fault_q    <= 1'b0;
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         mem_fault_q    <= mem_fault_d;
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign StallCycles = stall_cycles_q;
   assign FlushEvents = flush_events_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   localparam int TO = 4;
   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;

   typedef struct packed {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       rwm, rww;
      logic [2:0] src;
      logic       pc, mreq, rdy;
   } stim_t;

   typedef struct packed {
      logic [1:0]    fa, fb;
      logic [7:0]    ctl;
      logic [CW-1:0] sc, fe;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic          RegWriteM, RegWriteW, PCSrcE, MemReqM, DMemReadyM;
   logic [2:0]    ResultSrcE;
   logic [1:0]    ForwardAE, ForwardBE;
   logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault;
   logic [CW-1:0] StallCycles, FlushEvents;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW), .LOAD_SRC(3'b001)) dut (
      .clk(clk), .reset_n(reset_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
      .PCSrcE(PCSrcE), .MemReqM(MemReqM), .DMemReadyM(DMemReadyM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemFault(MemFault),
      .StallCycles(StallCycles), .FlushEvents(FlushEvents)
   );

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference: "waiting" = consecutive unready cycles since the memory stall began
   bit m_waiting, m_faulted;
   int m_waited, m_sc, m_fe;

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
      if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
      if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic step(input stim_t s, input bit rst);
      exp_t e;
      bit lw, ms, sf, sd, se, sm, fd, fe, fw;
      @(posedge clk);
      #1;
      reset_n = !rst;
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = {s.rs1d, s.rs2d, s.rs1e, s.rs2e, s.rde, s.rdm, s.rdw};
      {RegWriteM, RegWriteW, ResultSrcE} = {s.rwm, s.rww, s.src};
      {PCSrcE, MemReqM, DMemReadyM} = {s.pc, s.mreq, s.rdy};
      if (rst) begin
         m_waiting = 0; m_faulted = 0; m_waited = 0; m_sc = 0; m_fe = 0;
      end
      lw = (s.src == 3'b001) && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
      ms = s.mreq && !s.rdy;
      if (m_faulted || ms) begin
         {sf, sd, se, sm, fd, fe, fw} = 7'b1111_001;
      end else begin
         sf = lw; sd = lw; se = 0; sm = 0; fd = s.pc; fe = lw || s.pc; fw = 0;
      end
      e.fa  = ref_fwd(s.rs1e, s);
      e.fb  = ref_fwd(s.rs2e, s);
      e.ctl = {sf, sd, se, sm, fd, fe, fw, 1'(m_faulted)};
      e.sc  = CW'(m_sc);
      e.fe  = CW'(m_fe);
      exp_q.push_back(e);
      if (!rst) begin
         if (sf || sd || se || sm) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
         if (fd) m_fe = (m_fe < SAT) ? m_fe + 1 : SAT;
         if (!m_faulted) begin
            if (!m_waiting) begin
               if (ms) begin m_waiting = 1; m_waited = 1; end
            end else if (s.rdy) begin
               m_waiting = 0; m_waited = 0;
            end else if (m_waited == TO) begin
               m_faulted = 1;
            end else begin
               m_waited++;
            end
         end
      end
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
      s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
      s.rde  = 5'($urandom_range(0, 3)); s.rdm  = 5'($urandom_range(0, 3));
      s.rdw  = 5'($urandom_range(0, 3));
      s.rwm  = 1'($urandom_range(0, 1)); s.rww  = 1'($urandom_range(0, 1));
      s.src  = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom_range(0, 7));
      s.pc   = ($urandom_range(0, 4) == 0);
      s.mreq = ($urandom_range(0, 2) == 0);
      s.rdy  = ($urandom_range(0, 3) != 0);
      return s;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({ForwardAE, ForwardBE} !== {e.fa, e.fb})
               $display("FAIL fwd: got %b/%b want %b/%b", ForwardAE, ForwardBE, e.fa, e.fb);
            else n_pass++;
            n_checks++;
            if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault} !== e.ctl)
               $display("FAIL ctl(sF sD sE sM fD fE fW flt): got %b want %b",
                        {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault}, e.ctl);
            else n_pass++;
            n_checks++;
            if ({StallCycles, FlushEvents} !== {e.sc, e.fe})
               $display("FAIL counters: got sc=%0d fe=%0d want sc=%0d fe=%0d",
                        StallCycles, FlushEvents, e.sc, e.fe);
            else n_pass++;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      stim_t s, z;
      z = '0;
      reset_n = 1'b0;
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
      {RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, DMemReadyM} = '0;
      step(z, 1); step(z, 1); step(z, 0);

      s = z; s.rdm = 5; s.rdw = 5; s.rs1e = 5; s.rs2e = 5; s.rwm = 1; s.rww = 1;
      step(s, 0);
      s.rwm = 0; step(s, 0);
      step(z, 0);

      s = z; s.src = 3'b001; s.rde = 7; s.rs2d = 7;
      step(s, 0); step(z, 0);
      s.rde = 0; step(s, 0);

      s = z; s.pc = 1; step(s, 0); step(z, 0);
      s.src = 3'b001; s.rde = 7; s.rs1d = 7; step(s, 0); step(z, 0);

      step(z, 1);
      s = z; s.mreq = 1;
      for (int i = 0; i < 3; i++) step(s, 0);
      s.rdy = 1; step(s, 0); step(z, 0);

      step(z, 1);
      s = z; s.mreq = 1;
      for (int i = 0; i < 22; i++) step(s, 0);
      step(z, 0);
      step(z, 1); step(z, 0);

      for (int i = 0; i < 800; i++) step(rand_stim(), ($urandom_range(0, 63) == 0));

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expected entries never compared, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
